// File: rtl/cpu_boot_loader_if.sv
// Bus bundle between the program source, the boot loader and the CPU load port.
// The master side is the board/testbench; the slave side is the loader itself.
interface cpu_boot_loader_if;
   logic        start;
   logic [15:0] prog_len;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] instruction_in;
   logic [15:0] load_address;
   logic        load_instruction;
   logic        pc_reset;
   logic        busy;
   logic        done;
   logic        error;

   modport master (
      output start, prog_len, in_data, in_valid,
      input  in_ready, instruction_in, load_address, load_instruction,
      input  pc_reset, busy, done, error
   );

   modport slave (
      input  start, prog_len, in_data, in_valid,
      output in_ready, instruction_in, load_address, load_instruction,
      output pc_reset, busy, done, error
   );
endinterface

// File: rtl/cpu_boot_loader.sv
// Boot and program-load controller: keeps the CPU in reset while a program is
// streamed into instruction memory, holds reset a few extra cycles after the
// last write commits, then releases the CPU.
module cpu_boot_loader #(
   parameter int          DEPTH       = 256,
   parameter logic [15:0] BASE_ADDR   = 16'h0000,
   parameter int          HOLD_CYCLES = 2
) (
   input logic             clk,
   input logic             reset_n,
   cpu_boot_loader_if.slave bus
);

   localparam logic [16:0] DEPTH_W   = 17'(DEPTH);
   localparam logic [3:0]  HOLD_LAST = 4'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      DRAIN,
      HOLD,
      RUN
   } state_t;

   state_t      state;
   state_t      next_state;
   logic [15:0] word_count;
   logic [15:0] prog_len_q;
   logic [3:0]  hold_count;
   logic [15:0] instruction_q;
   logic [15:0] address_q;
   logic        strobe_q;
   logic        done_q;
   logic        error_q;

   logic        start_seen;
   logic        start_illegal;
   logic        start_legal;
   logic        handshake;
   logic        last_word;

   // start only counts while the CPU is either parked or running
   assign start_seen    = bus.start && ((state == IDLE) || (state == RUN));
   assign start_illegal = start_seen && ({1'b0, bus.prog_len} > DEPTH_W);
   assign start_legal   = start_seen && !start_illegal;
   assign handshake     = bus.in_valid && (state == LOAD);
   assign last_word     = handshake && ((word_count + 16'd1) == prog_len_q);

   assign bus.in_ready         = (state == LOAD);
   assign bus.pc_reset         = (state != RUN);
   assign bus.busy             = (state == LOAD) || (state == DRAIN) || (state == HOLD);
   assign bus.done             = done_q;
   assign bus.error            = error_q;
   assign bus.instruction_in   = instruction_q;
   assign bus.load_address     = address_q;
   assign bus.load_instruction = strobe_q;

   // State register; reset parks the CPU in IDLE with pc_reset high
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state selection; a zero-length program skips straight to the hold phase
   always_comb begin
      next_state = state;
      case (state)
         IDLE, RUN: begin
            if (start_legal) begin
               next_state = (bus.prog_len == 16'd0) ? HOLD : LOAD;
            end
         end
         LOAD: begin
            if (last_word) begin
               next_state = DRAIN;
            end
         end
         DRAIN: begin
            next_state = HOLD;
         end
         HOLD: begin
            if (hold_count == HOLD_LAST) begin
               next_state = RUN;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Write port, word/hold counters and status flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word_count    <= 16'd0;
         prog_len_q    <= 16'd0;
         hold_count    <= 4'd0;
         instruction_q <= 16'd0;
         address_q     <= 16'd0;
         strobe_q      <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
      end else begin
         strobe_q <= handshake;
         if (handshake) begin
            instruction_q <= bus.in_data;
            address_q     <= BASE_ADDR + word_count;
            word_count    <= word_count + 16'd1;
         end
         if (start_legal) begin
            prog_len_q <= bus.prog_len;
            word_count <= 16'd0;
         end
         hold_count <= (state == HOLD) ? (hold_count + 4'd1) : 4'd0;
         done_q     <= (state == HOLD) && (next_state == RUN);
         if (start_illegal) begin
            error_q <= 1'b1;
         end else if (start_legal) begin
            error_q <= 1'b0;
         end
      end
   end

endmodule

// File: doc/cpu_boot_loader.md
# cpu_boot_loader

Boot and program-load controller for the 16-bit single-cycle CPU. It holds the CPU in reset (`pc_reset`) while it streams a program from an external valid/ready source into instruction memory through the CPU's `instruction_in` / `load_address` / `load_instruction` port. When the last word is written, it holds reset for a fixed number of cycles, then releases the CPU. It sits between the board/testbench program source and the top-level CPU instance.

## Interface
- `DEPTH`, 256: instruction-memory capacity in words; maximum legal `prog_len`.
- `BASE_ADDR`, 16'h0000: instruction-memory address of the first loaded word.
- `HOLD_CYCLES`, 2: cycles `pc_reset` stays high after the final write, before release; legal range 1–15.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a load; sampled in IDLE and RUN only.
- `prog_len`  in  16  number of words to load; sampled in the same cycle as an accepted `start`.
- `in_data`  in  16  program word from the source.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a word this cycle.
- `instruction_in`  out  16  word to the CPU instruction-memory write port; registered.
- `load_address`  out  16  write address to the CPU; registered.
- `load_instruction`  out  1  write strobe to the CPU; registered; high for exactly one cycle per word.
- `pc_reset`  out  1  active-high CPU reset (PC and register file).
- `busy`  out  1  high in LOAD, DRAIN, HOLD.
- `done`  out  1  one-cycle pulse on entry to RUN.
- `error`  out  1  sticky; set when `prog_len` > `DEPTH`; cleared by the next accepted legal `start`.

## Operation
States: IDLE, LOAD, DRAIN, HOLD, RUN.
- Reset values while `reset_n` = 0: state IDLE, `pc_reset` = 1, `in_ready` = 0, `load_instruction` = 0, `load_address` = 0, `instruction_in` = 0, `busy` = 0, `done` = 0, `error` = 0, word count = 0, hold counter = 0.
- IDLE: `pc_reset` = 1.
  - `start` with `prog_len` > `DEPTH`: set `error`, stay IDLE.
  - `start` with `prog_len` = 0: go to HOLD.
  - Any other `start`: latch `prog_len`, clear count, go to LOAD.
- LOAD: `in_ready` = 1, `pc_reset` = 1.
  - On each handshake (`in_valid` & `in_ready`), the next edge registers `instruction_in` = `in_data` and `load_address` = `BASE_ADDR` + count, and pulses `load_instruction`. Count increments.
  - The handshake that brings count to `prog_len` moves the state to DRAIN. No further words are accepted.
  - `in_valid` low stalls indefinitely with no timeout.
- DRAIN: one cycle. The final `load_instruction` pulse is visible this cycle and memory commits at the closing edge. Then go to HOLD.
- HOLD: `pc_reset` = 1 for `HOLD_CYCLES` cycles, counted by the hold counter. Then go to RUN.
- RUN: `pc_reset` = 0. `done` pulses in the first RUN cycle.
  - `start` re-evaluates exactly as in IDLE.
  - A legal `start` asserts `pc_reset` from the next edge and enters LOAD or HOLD.
  - An illegal `start` sets `error` and stays in RUN; the CPU keeps running.
- `start` in LOAD, DRAIN, or HOLD is ignored.
- Address arithmetic is 16-bit modulo. `BASE_ADDR` + `DEPTH` − 1 must not wrap; this is the integrator's responsibility.
- `load_instruction` is 0 in every cycle that does not directly follow a handshake.

## Timing
- Handshake at edge N → `load_instruction` / `load_address` / `instruction_in` valid in cycle N+1, written to memory at edge N+2.
- Back-to-back handshakes give one write per cycle (full throughput).
- After the last handshake, `in_ready` drops in the next cycle.
- Last handshake at edge N → DRAIN in cycle N+1 → HOLD for cycles N+2 … N+1+`HOLD_CYCLES` → RUN from cycle N+2+`HOLD_CYCLES`.
- `pc_reset` is low no earlier than one full cycle after the final write commits.
- `reset_n` asserted mid-LOAD clears everything immediately (asynchronously), including any pending write strobe. Deassertion returns to IDLE with `pc_reset` high. A partial program is never released.

## Test plan
- Reset, then `start` with `prog_len` = 4 and continuous `in_valid`, words A0..A3 → writes to addresses 0,1,2,3 on consecutive cycles. `pc_reset` falls exactly 1+2 cycles after the last strobe; `done` pulses once.
- `prog_len` = 3 with `in_valid` toggling 1,0,1,0,1 → exactly 3 strobes at addresses 0,1,2 with the correct data, and no strobe in any stall cycle.
- `prog_len` = 300 with `DEPTH` = 256 → `error` = 1, state stays IDLE, no strobes. A following `start` with `prog_len` = 1 → `error` clears and the load completes.
- `prog_len` = 0 → no strobes; RUN is reached after `HOLD_CYCLES` with `pc_reset` = 1 throughout.
- `reset_n` pulsed low after 2 of 5 words → `load_instruction` drops at once, `pc_reset` stays 1, and `in_ready` = 0 until a new `start`.
- In RUN, `start` with `prog_len` = 2 → `pc_reset` rises the next cycle, a reload to addresses 0,1 follows, then release. `start` issued during HOLD is ignored.
